// File: rtl/lsu.sv
// Load/store unit: accepts one memory request per instruction, sequences
// word-wide RAM accesses (read-modify-write for sub-word stores) and returns
// sign/zero-extended load data to the register file.
module lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [REG_AW-1:0] req_rd_i,
  output logic [ADDR_W-1:0] ram_raddr_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_waddr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic              reg_we_o,
  output logic [REG_AW-1:0] reg_waddr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              hold_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, RD, DATA, WR} state_t;

  state_t state_q, state_d;

  // Latched request fields
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              we_q;
  logic [REG_AW-1:0] rd_q;

  // Registered outputs
  logic [ADDR_W-1:0] ram_raddr_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_waddr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              reg_we_q;
  logic [REG_AW-1:0] reg_waddr_q;
  logic [DATA_W-1:0] reg_wdata_q;
  logic              err_q;

  // Request decode (only meaningful in IDLE)
  logic req_is_word, req_is_half, req_misalign, req_accept, req_direct_wr;
  logic [ADDR_W-1:0] req_word_addr, lat_word_addr;

  assign req_is_word   = req_size_i[1];          // size 3 behaves as word
  assign req_is_half   = (req_size_i == 2'd1);
  assign req_misalign  = (req_is_half && req_addr_i[0]) ||
                         (req_is_word && (req_addr_i[1:0] != 2'b00));
  assign req_accept    = (state_q == IDLE) && req_valid_i && !req_misalign;
  assign req_direct_wr = req_we_i && req_is_word;  // full-word store skips the read
  assign req_word_addr = {req_addr_i[ADDR_W-1:2], 2'b00};
  assign lat_word_addr = {addr_q[ADDR_W-1:2], 2'b00};

  // Byte-lane enables for the latched access
  logic [3:0] lane_en;
  always_comb begin
    lane_en = 4'b0000;
    if (size_q[1]) begin
      lane_en = 4'b1111;
    end else if (size_q == 2'd1) begin
      lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
    end else begin
      lane_en = 4'b0001 << addr_q[1:0];
    end
  end

  // Per-lane read split and store merge
  logic [7:0]        rd_lane [4];
  logic [7:0]        st_lane [4];
  logic [DATA_W-1:0] merged;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_lane[gi] = ram_rdata_i[gi*8 +: 8];
      if ((gi % 2) == 1) begin : g_odd
        // Odd lanes take the upper halfword byte for halfword stores
        assign st_lane[gi] = (size_q == 2'd1) ? wdata_q[15:8] : wdata_q[7:0];
      end else begin : g_even
        assign st_lane[gi] = wdata_q[7:0];
      end
      assign merged[gi*8 +: 8] = lane_en[gi] ? st_lane[gi] : rd_lane[gi];
    end
  endgenerate

  // Load lane selection and sign/zero extension
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_result;
  always_comb begin
    ld_byte = rd_lane[addr_q[1:0]];
    ld_half = addr_q[1] ? ram_rdata_i[31:16] : ram_rdata_i[15:0];
    case (size_q)
      2'd0:    ld_result = {{(DATA_W-8){~uns_q & ld_byte[7]}}, ld_byte};
      2'd1:    ld_result = {{(DATA_W-16){~uns_q & ld_half[15]}}, ld_half};
      default: ld_result = ram_rdata_i;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_accept) state_d = req_direct_wr ? WR : RD;
      RD:   state_d = DATA;
      DATA: state_d = we_q ? WR : IDLE;
      WR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, RAM port and write-back registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      rd_q        <= '0;
      ram_raddr_q <= '0;
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q    <= (state_q == IDLE) && req_valid_i && req_misalign;
      ram_we_q <= 1'b0;
      reg_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_accept) begin
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            we_q    <= req_we_i;
            rd_q    <= req_rd_i;
            if (req_direct_wr) begin
              ram_we_q    <= 1'b1;
              ram_waddr_q <= req_word_addr;
              ram_wdata_q <= req_wdata_i;
            end else begin
              ram_raddr_q <= req_word_addr;
            end
          end
        end
        DATA: begin
          if (we_q) begin
            ram_we_q    <= 1'b1;
            ram_waddr_q <= lat_word_addr;
            ram_wdata_q <= merged;
          end else begin
            reg_we_q    <= (rd_q != '0);
            reg_waddr_q <= rd_q;
            reg_wdata_q <= ld_result;
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_raddr_o = ram_raddr_q;
  assign ram_we_o    = ram_we_q;
  assign ram_waddr_o = ram_waddr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign reg_we_o    = reg_we_q;
  assign reg_waddr_o = reg_waddr_q;
  assign reg_wdata_o = reg_wdata_q;
  assign hold_o      = (state_q != IDLE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus pushes expected RAM writes, register
// write-backs and error pulses; a forked monitor pops and compares them.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] ram_raddr, ram_rdata, ram_waddr, ram_wdata;
  logic        ram_we;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        hold, err;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_we_i(req_we), .req_size_i(req_size),
    .req_unsigned_i(req_unsigned), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_rd_i(req_rd),
    .ram_raddr_o(ram_raddr), .ram_rdata_i(ram_rdata), .ram_we_o(ram_we),
    .ram_waddr_o(ram_waddr), .ram_wdata_o(ram_wdata),
    .reg_we_o(reg_we), .reg_waddr_o(reg_waddr), .reg_wdata_o(reg_wdata),
    .hold_o(hold), .err_o(err)
  );

  // Behavioural RAM: one-cycle read latency, bench preload port
  logic [31:0] mem [0:255];
  logic        pre_we = 1'b0;
  logic [31:0] pre_addr = '0, pre_data = '0;
  always @(posedge clk) begin
    ram_rdata <= mem[ram_raddr[9:2]];
    if (ram_we) mem[ram_waddr[9:2]] <= ram_wdata;
    else if (pre_we) mem[pre_addr[9:2]] <= pre_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;   // 0 ram write, 1 reg write-back, 2 error pulse
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic string kname(input int k);
    case (k)
      0: return "ramw";
      1: return "regw";
      default: return "err";
    endcase
  endfunction

  task automatic check_evt(input int kind, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_%s: got addr=%h data=%h cyc=%0d, want no event", kname(kind), a, d, cyc);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != kind || e.addr != a || e.data != d || e.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s: got %s addr=%h data=%h cyc=%0d, want %s addr=%h data=%h cyc=%0d",
                 e.name, kname(kind), a, d, cyc, kname(e.kind), e.addr, e.data, e.cyc);
      end else begin
        $display("ok   %s: %s addr=%h data=%h cyc=%0d", e.name, kname(kind), a, d, cyc);
      end
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (ram_we) check_evt(0, ram_waddr, ram_wdata);
      if (reg_we) check_evt(1, {27'b0, reg_waddr}, reg_wdata);
      if (err)    check_evt(2, 32'h0, 32'h0);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end else begin
      $display("ok   %s: %h", nm, got);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // Issue one request from a negedge; expect one event (kind<0: none) at
  // accept-edge + lat, and hold_o high for exp_hold cycles.
  task automatic issue(input string nm, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input int kind, input logic [31:0] eaddr,
                       input logic [31:0] edata, input int lat, input int exp_hold,
                       input bit keep);
    exp_t e;
    int   acc;
    int   n;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_rd       = rd;
    req_valid    = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    if (!keep) req_valid = 1'b0;
    if (kind >= 0) begin
      e.kind = kind;
      e.addr = eaddr;
      e.data = edata;
      e.cyc  = acc + lat;
      e.name = nm;
      sb_q.push_back(e);
    end
    n = 0;
    @(negedge clk);
    while (hold && n < 10) begin
      n++;
      @(negedge clk);
    end
    if (keep) req_valid = 1'b0;
    chk({nm, "_hold"}, n, exp_hold);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    fork
      monitor_loop();
    join_none
    repeat (3) @(negedge clk);
    chk("rst_hold",      {31'b0, hold}, 32'h0);
    chk("rst_ram_we",    {31'b0, ram_we}, 32'h0);
    chk("rst_reg_we",    {31'b0, reg_we}, 32'h0);
    chk("rst_err",       {31'b0, err}, 32'h0);
    chk("rst_ram_raddr", ram_raddr, 32'h0);
    chk("rst_ram_waddr", ram_waddr, 32'h0);
    chk("rst_reg_wdata", reg_wdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    preload(32'h20, 32'h80FF7F01);
    preload(32'h30, 32'h11223344);
    preload(32'h40, 32'h55667788);

    // name         we size uns addr          wdata         rd kind eaddr         edata         lat hold keep
    issue("sw_dead",  1, 2, 0, 32'h10,       32'hDEADBEEF, 0,  0, 32'h10,       32'hDEADBEEF, 0, 1, 0);
    issue("lw_dead",  0, 2, 0, 32'h10,       32'h0,        5,  1, 32'd5,        32'hDEADBEEF, 2, 2, 0);
    issue("lb_23",    0, 0, 0, 32'h23,       32'h0,        1,  1, 32'd1,        32'hFFFFFF80, 2, 2, 0);
    issue("lbu_23",   0, 0, 1, 32'h23,       32'h0,        2,  1, 32'd2,        32'h00000080, 2, 2, 0);
    issue("lb_21",    0, 0, 0, 32'h21,       32'h0,        3,  1, 32'd3,        32'h0000007F, 2, 2, 0);
    issue("lh_22",    0, 1, 0, 32'h22,       32'h0,        4,  1, 32'd4,        32'hFFFF80FF, 2, 2, 0);
    issue("lhu_20",   0, 1, 1, 32'h20,       32'h0,        6,  1, 32'd6,        32'h00007F01, 2, 2, 0);
    issue("sb_31",    1, 0, 0, 32'h31,       32'h123456AA, 0,  0, 32'h30,       32'h1122AA44, 2, 3, 0);
    issue("sh_32",    1, 1, 0, 32'h32,       32'hCAFEBEEF, 0,  0, 32'h30,       32'hBEEFAA44, 2, 3, 0);
    issue("lw_30",    0, 2, 0, 32'h30,       32'h0,        7,  1, 32'd7,        32'hBEEFAA44, 2, 2, 0);
    issue("sb_33",    1, 0, 0, 32'h33,       32'h0000005A, 0,  0, 32'h30,       32'h5AEFAA44, 2, 3, 0);
    issue("lw_mis",   0, 2, 0, 32'h06,       32'h0,        8,  2, 32'h0,        32'h0,        0, 0, 0);
    issue("sh_mis",   1, 1, 0, 32'h05,       32'h1234,     0,  2, 32'h0,        32'h0,        0, 0, 0);
    issue("lw_rd0",   0, 2, 0, 32'h10,       32'h0,        0, -1, 32'h0,        32'h0,        0, 2, 0);
    issue("sw_keep",  1, 2, 0, 32'h50,       32'h0BADF00D, 0,  0, 32'h50,       32'h0BADF00D, 0, 1, 1);
    issue("lw_keep",  0, 2, 0, 32'h50,       32'h0,        9,  1, 32'd9,        32'h0BADF00D, 2, 2, 1);
    issue("lw_b2b_a", 0, 2, 0, 32'h20,       32'h0,        10, 1, 32'd10,       32'h80FF7F01, 2, 2, 0);
    issue("lw_b2b_b", 0, 2, 0, 32'h30,       32'h0,        11, 1, 32'd11,       32'h5AEFAA44, 2, 2, 0);
    issue("sw_top",   1, 2, 0, 32'hFFFFFFFC, 32'h13579BDF, 0,  0, 32'hFFFFFFFC, 32'h13579BDF, 0, 1, 0);
    issue("lw_top",   0, 2, 0, 32'hFFFFFFFC, 32'h0,        12, 1, 32'd12,       32'h13579BDF, 2, 2, 0);

    // Abort a read-modify-write while it is in DATA
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h41; req_wdata = 32'h99; req_rd = '0;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);   // RD
    @(negedge clk);   // DATA
    rst = 1'b1;
    @(negedge clk);
    chk("abort_hold",   {31'b0, hold}, 32'h0);
    chk("abort_ram_we", {31'b0, ram_we}, 32'h0);
    chk("abort_reg_we", {31'b0, reg_we}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue("lw_abort", 0, 2, 0, 32'h40, 32'h0, 13, 1, 32'd13, 32'h55667788, 2, 2, 0);

    repeat (5) @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
